seq_gen: RTL and testbench
==========================

# seq_gen

Serial pattern transmitter. Shifts a programmable W-bit pattern out MSB-first on a single-bit line, repeats it a programmable number of times with optional idle gaps, and signals completion. Its `dout` is the stimulus source for the sequence detector's `din`. It is used in loopback self-test and as a synthesizable bench driver.

## Interface
- `W`, default 4: pattern width in bits, 2..16.
- `PATTERN_RST`, default 4'b0101: pattern register value after reset.
- `CNT_W`, default 8: width of the repeat count.
- `GAP_W`, default 4: width of the gap length.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `load` in 1: in IDLE, capture `pattern_in` into the pattern register.
- `pattern_in` in W: new pattern value.
- `start` in 1: in IDLE, begin transmission.
- `stop` in 1: abort the current transmission.
- `rep` in CNT_W: number of repetitions; 0 means continuous until `stop`.
- `gap` in GAP_W: number of idle cycles between repetitions.
- `dout` in/out: out 1, registered serial data.
- `valid` out 1: high while `dout` carries a pattern bit.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after normal completion.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE:
  - `load` updates the pattern register.
  - On `start`, capture `rep` and `gap` into internal registers, preload the shift register from the pattern register, set bit counter = W-1, then go to SHIFT.
- SHIFT:
  - `dout` = shift-register MSB and `valid` = 1.
  - The shift register shifts left each cycle.
  - When the bit counter reaches 0, the repetition ends.
  - If it was the last repetition, go to IDLE and pulse `done`.
  - Otherwise, if captured gap > 0, go to GAP; if gap = 0, reload the pattern and stay in SHIFT with no bubble.
- GAP:
  - `dout` = 0, `valid` = 0.
  - Count down the captured gap, then reload the pattern and enter SHIFT.
- Repetition counter:
  - Captured `rep` decrements at the end of each repetition; it is last when the value is 1.
  - With captured rep = 0 the block never decrements and never completes.
- `stop` in SHIFT or GAP goes to IDLE on the next edge. `dout`, `valid` and `busy` clear, and `done` does not pulse.
- Ignored inputs:
  - `load` and `start` outside IDLE have no effect. The in-flight pattern, rep and gap are frozen at `start`.
  - `stop` in IDLE has no effect.
- Same-cycle `start` and `stop` in IDLE: `stop` wins and the block stays IDLE.
- Same-cycle `load` and `start` in IDLE: the transmission uses the new `pattern_in`.
- Reset, at any time and asynchronously:
  - state = IDLE; `dout`, `valid`, `busy`, `done` = 0.
  - Pattern register = PATTERN_RST; counters = 0.

## Timing
- All outputs are registered.
- First pattern bit on `dout` appears in the first cycle after the edge that samples `start`, i.e. latency 1.
- Busy duration is N·W + (N−1)·G cycles for N ≥ 1. No trailing gap follows the last repetition.
- `done` is high in the single cycle after the last bit, coincident with `busy` = 0.
- A new `start` is accepted in the same cycle `done` is high, giving back-to-back frames with a one-cycle gap.
- `valid` equals (state == SHIFT) exactly.

## Structure
- Package `seq_pkg`:
  - state enum {IDLE, SHIFT, GAP};
  - default widths;
  - PATTERN_RST default 4'b0101.
- Sub-module `seq_gen_shreg`: W-bit parallel-load, shift-left register with MSB output and a bit down-counter (ports `clk`, `reset`, `ld`, `sh`, `d`, `msb`, `last`).
- Top level holds the FSM, repeat counter and gap counter.

## Test plan
- Reset mid-SHIFT:
  - Assert `reset` with no clock edge; outputs must go to 0 immediately.
  - After release, `start` with rep=1 must emit 0,1,0,1 from PATTERN_RST.
- `start` with rep=1, gap=0 at edge k:
  - `dout` = 0,1,0,1 with `valid` = 1 at cycles k+1..k+4.
  - `done` = 1 and `busy` = 0 at k+5.
- rep=3, gap=2, looped into the sequence detector:
  - `dout` = 0101 00 0101 00 0101 over 16 cycles.
  - Detector `z` asserts exactly 3 times; `done` fires once.
- `load` pattern 4'b1100 while busy:
  - The in-flight frame is unchanged.
  - `load` again in IDLE, then `start` with rep=2, gap=0: `dout` = 11001100.
- rep=0 (continuous):
  - After 10 full repetitions, assert `stop` mid-pattern on bit 2.
  - Next cycle: `busy` = `valid` = `dout` = 0, and `done` is never asserted.
- Same-cycle `start` and `stop` in IDLE: the block stays IDLE and `busy` remains 0.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_pkg : shared state encoding and default widths for seq_gen | rev 1.0
// ----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int unsigned DEF_W     = 4;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_GAP_W = 4;

  localparam logic [3:0] DEF_PATTERN_RST = 4'b0101;

endpackage
`default_nettype wire

// File: rtl/seq_gen_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_gen_if : control/data bundle for seq_gen (master = driver) | rev 1.0
// ----------------------------------------------------------------------------
interface seq_gen_if
  import seq_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned GAP_W = DEF_GAP_W
);

  logic             load;
  logic [W-1:0]     pattern_in;
  logic             start;
  logic             stop;
  logic [CNT_W-1:0] rep;
  logic [GAP_W-1:0] gap;
  logic             dout;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output load, pattern_in, start, stop, rep, gap,
    input  dout, valid, busy, done
  );

  modport slave (
    input  load, pattern_in, start, stop, rep, gap,
    output dout, valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/seq_gen_shreg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_gen_shreg : parallel-load shift-left register with bit down-counter | rev 1.0
// ----------------------------------------------------------------------------
module seq_gen_shreg
  import seq_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         ld,
  input  wire logic         sh,
  input  wire logic [W-1:0] d,
  output logic              msb,
  output logic              last
);

  localparam int unsigned CW = $clog2(W);

  logic [W-1:0]  sr_q;
  logic [CW-1:0] cnt_q;

  // Shifting fills with zeros, so a fully shifted-out register drives 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (ld) begin
      sr_q  <= d;
      cnt_q <= CW'(W - 1);
    end else if (sh) begin
      sr_q  <= {sr_q[W-2:0], 1'b0};
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign msb  = sr_q[W-1];
  assign last = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_gen : serial pattern transmitter, MSB-first, repeat count and idle gaps | rev 1.0
// ----------------------------------------------------------------------------
module seq_gen
  import seq_pkg::*;
#(
  parameter int unsigned W           = DEF_W,
  parameter logic [W-1:0] PATTERN_RST = W'(DEF_PATTERN_RST),
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned GAP_W       = DEF_GAP_W
) (
  input  wire logic clk,
  input  wire logic reset,
  seq_gen_if.slave  bus
);

  state_t           state_q, state_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             valid_q, busy_q, done_q;
  logic             done_d;

  logic             sr_ld, sr_sh, sr_msb, sr_last;
  logic [W-1:0]     sr_din;

  seq_gen_shreg #(.W(W)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .ld    (sr_ld),
    .sh    (sr_sh),
    .d     (sr_din),
    .msb   (sr_msb),
    .last  (sr_last)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    done_d  = 1'b0;
    sr_ld   = 1'b0;
    sr_sh   = 1'b0;
    sr_din  = pat_q;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          pat_d = bus.pattern_in;
        end
        if (bus.start && !bus.stop) begin
          rep_d   = bus.rep;
          gap_d   = bus.gap;
          sr_ld   = 1'b1;
          sr_din  = bus.load ? bus.pattern_in : pat_q;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.stop) begin
          // Loading zeros keeps dout low for the whole idle period after abort.
          sr_ld   = 1'b1;
          sr_din  = '0;
          state_d = IDLE;
        end else if (!sr_last) begin
          sr_sh = 1'b1;
        end else if (rep_q == CNT_W'(1)) begin
          sr_sh   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          if (rep_q != '0) begin
            rep_d = rep_q - CNT_W'(1);
          end
          if (gap_q != '0) begin
            sr_sh   = 1'b1;
            gcnt_d  = gap_q;
            state_d = GAP;
          end else begin
            sr_ld = 1'b1;
          end
        end
      end

      GAP: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (gcnt_q <= GAP_W'(1)) begin
          sr_ld   = 1'b1;
          state_d = SHIFT;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= PATTERN_RST;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      valid_q <= (state_d == SHIFT);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign bus.dout  = sr_msb;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_gen : directed vector table plus corner-case sequences for seq_gen | rev 1.0
// ----------------------------------------------------------------------------
module tb_seq_gen;

  typedef struct {
    logic       load;
    logic [3:0] pat;
    logic       start;
    logic       stop;
    logic [7:0] rep;
    logic [3:0] gap;
    logic [3:0] exp;   // {dout, valid, busy, done}
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_gen_if #(.W(4), .CNT_W(8), .GAP_W(4)) bus ();

  seq_gen #(
    .W           (4),
    .PATTERN_RST (4'b0101),
    .CNT_W       (8),
    .GAP_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [3:0] p, input logic st,
                       input logic sp, input logic [7:0] r, input logic [3:0] g);
    bus.load       = ld;
    bus.pattern_in = p;
    bus.start      = st;
    bus.stop       = sp;
    bus.rep        = r;
    bus.gap        = g;
  endtask

  task automatic idle_in();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 4'd0);
  endtask

  task automatic add(input logic ld, input logic [3:0] p, input logic st, input logic sp,
                     input logic [7:0] r, input logic [3:0] g, input logic [3:0] e);
    vecs.push_back('{load: ld, pat: p, start: st, stop: sp, rep: r, gap: g, exp: e});
  endtask

  task automatic add_idle(input logic [3:0] e);
    add(1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 4'd0, e);
  endtask

  initial begin
    logic [15:0] s;
    logic [15:0] vm;
    logic [3:0]  win;
    int          hits;
    int          dcnt;
    int          bad;

    idle_in();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_dout",  {31'd0, bus.dout},  32'd0);
    chk("rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("rst_done",  {31'd0, bus.done},  32'd0);
    reset = 1'b0;
    tick();

    // rep=1 gap=0 from reset pattern 0101, then start+stop and stop in IDLE
    add(1'b0, 4'h0, 1'b1, 1'b0, 8'd1, 4'd0, 4'b0110);
    add_idle(4'b1110);
    add_idle(4'b0110);
    add_idle(4'b1110);
    add_idle(4'b0001);
    add(1'b0, 4'h0, 1'b1, 1'b1, 8'd1, 4'd0, 4'b0000);
    add(1'b0, 4'h0, 1'b0, 1'b1, 8'd0, 4'd0, 4'b0000);
    // same-cycle load+start of 1001, rep=2 gap=1
    add(1'b1, 4'b1001, 1'b1, 1'b0, 8'd2, 4'd1, 4'b1110);
    add_idle(4'b0110);
    add_idle(4'b0110);
    add_idle(4'b1110);
    add_idle(4'b0010);
    add_idle(4'b1110);
    add_idle(4'b0110);
    add_idle(4'b0110);
    add_idle(4'b1110);
    add_idle(4'b0001);
    // back-to-back start in the done cycle
    add(1'b0, 4'h0, 1'b1, 1'b0, 8'd1, 4'd0, 4'b1110);
    add_idle(4'b0110);
    add_idle(4'b0110);
    add_idle(4'b1110);
    add_idle(4'b0001);
    add_idle(4'b0000);

    foreach (vecs[i]) begin
      drive(vecs[i].load, vecs[i].pat, vecs[i].start, vecs[i].stop, vecs[i].rep, vecs[i].gap);
      tick();
      chk($sformatf("vec%0d_dout", i),  {31'd0, bus.dout},  {31'd0, vecs[i].exp[3]});
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.valid}, {31'd0, vecs[i].exp[2]});
      chk($sformatf("vec%0d_busy", i),  {31'd0, bus.busy},  {31'd0, vecs[i].exp[1]});
      chk($sformatf("vec%0d_done", i),  {31'd0, bus.done},  {31'd0, vecs[i].exp[0]});
    end
    idle_in();

    // rep=3 gap=2 stream with an overlapping 0101 window detector
    s = '0; vm = '0; win = '0; hits = 0; dcnt = 0;
    drive(1'b1, 4'b0101, 1'b1, 1'b0, 8'd3, 4'd2);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) idle_in();
      s   = {s[14:0], bus.dout};
      vm  = {vm[14:0], bus.valid};
      win = {win[2:0], bus.dout};
      if (i >= 3 && win == 4'b0101) hits++;
      if (bus.done) dcnt++;
    end
    chk("gap_stream", {16'd0, s},  {16'd0, 16'b0101_00_0101_00_0101});
    chk("gap_valid",  {16'd0, vm}, {16'd0, 16'b1111_00_1111_00_1111});
    chk("gap_hits",   hits, 32'd3);
    chk("gap_early_done", dcnt, 32'd0);
    tick();
    chk("gap_done", {31'd0, bus.done}, 32'd1);
    chk("gap_busy", {31'd0, bus.busy}, 32'd0);
    tick();

    // load while busy must not disturb the frame or the pattern register
    s = '0;
    drive(1'b0, 4'h0, 1'b1, 1'b0, 8'd1, 4'd0);
    tick();
    s = {s[14:0], bus.dout};
    drive(1'b1, 4'b1100, 1'b0, 1'b0, 8'd0, 4'd0);
    tick();
    s = {s[14:0], bus.dout};
    idle_in();
    tick();
    s = {s[14:0], bus.dout};
    tick();
    s = {s[14:0], bus.dout};
    chk("busy_load_frame", {28'd0, s[3:0]}, 32'h5);
    tick();
    chk("busy_load_done", {31'd0, bus.done}, 32'd1);
    s = '0;
    drive(1'b0, 4'h0, 1'b1, 1'b0, 8'd1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) idle_in();
      s = {s[14:0], bus.dout};
    end
    chk("busy_load_kept", {28'd0, s[3:0]}, 32'h5);
    tick();
    drive(1'b1, 4'b1100, 1'b0, 1'b0, 8'd0, 4'd0);
    tick();
    s = '0; vm = '0;
    drive(1'b0, 4'h0, 1'b1, 1'b0, 8'd2, 4'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) idle_in();
      s  = {s[14:0], bus.dout};
      vm = {vm[14:0], bus.valid};
    end
    chk("idle_load_stream", {24'd0, s[7:0]},  32'hCC);
    chk("idle_load_valid",  {24'd0, vm[7:0]}, 32'hFF);
    tick();
    chk("idle_load_done", {31'd0, bus.done}, 32'd1);
    tick();

    // continuous mode with pattern 1100, stop on bit 2 of repetition 11
    bad = 0; dcnt = 0;
    drive(1'b0, 4'h0, 1'b1, 1'b0, 8'd0, 4'd0);
    for (int i = 0; i < 43; i++) begin
      tick();
      if (i == 0) idle_in();
      if (bus.dout !== ((i % 4) < 2) || bus.valid !== 1'b1) bad++;
      if (bus.done) dcnt++;
    end
    chk("cont_stream_errs", bad, 32'd0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("cont_stop_busy",  {31'd0, bus.busy},  32'd0);
    chk("cont_stop_valid", {31'd0, bus.valid}, 32'd0);
    chk("cont_stop_dout",  {31'd0, bus.dout},  32'd0);
    for (int i = 0; i < 4; i++) begin
      if (bus.done) dcnt++;
      tick();
    end
    chk("cont_never_done", dcnt, 32'd0);

    // asynchronous reset mid-SHIFT while dout is high
    drive(1'b0, 4'h0, 1'b1, 1'b0, 8'd0, 4'd0);
    tick();
    idle_in();
    tick();
    chk("pre_rst_dout", {31'd0, bus.dout}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_dout",  {31'd0, bus.dout},  32'd0);
    chk("async_rst_valid", {31'd0, bus.valid}, 32'd0);
    chk("async_rst_busy",  {31'd0, bus.busy},  32'd0);
    chk("async_rst_done",  {31'd0, bus.done},  32'd0);
    tick();
    reset = 1'b0;
    tick();
    s = '0;
    drive(1'b0, 4'h0, 1'b1, 1'b0, 8'd1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) idle_in();
      s = {s[14:0], bus.dout};
    end
    chk("post_rst_pattern", {28'd0, s[3:0]}, 32'h5);
    tick();
    chk("post_rst_done", {31'd0, bus.done}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
